arb_contador: RTL and testbench
===============================

ARB_CONTADOR -- requirements
Module: arb_contador

Interface
REQ-001 Parameter: W, 8, width of requester count values and of datapath count register.
REQ-002 Clock and reset: clk (single clock, all state on rising edge); rst, asynchronous, active-high.
REQ-003 clk  in  1  system clock.
REQ-004 rst  in  1  asynchronous active-high reset.
REQ-005 req0, req1  in  1 each  job request from requester 0 / 1; held high with val stable until matching done.
REQ-006 val0, val1  in  W each  countdown value of requester 0 / 1.
REQ-007 zero  in  1  datapath flag, count register == 0.
REQ-008 ld  out  1  datapath load strobe, count register <= val.
REQ-009 val  out  W  muxed value for datapath: val0 when sel=0, val1 when sel=1.
REQ-010 sel  out  1  index of granted requester.
REQ-011 dec  out  1  datapath decrement strobe.
REQ-012 gnt0, gnt1  out  1 each  grant level, requester owns datapath.
REQ-013 done0, done1  out  1 each  one-cycle job-complete pulse.
REQ-014 pronto  out  1  high when idle, no job in progress.
REQ-015 njobs  out  8  count of completed jobs, wraps 255 -> 0.

Function
REQ-016 FSM states: IDLE, LOAD, CONTA, FIM; state register and all outputs registered or decoded from state only (no combinational path req -> outputs except val mux).
REQ-017 IDLE: pronto=1; no req -> stay; any req -> LOAD with sel latched per REQ-018.
REQ-018 Arbitration round-robin: pointer prio (reset 0); both req high -> grant requester prio; single req -> grant it; prio <= ~granted index on entry to FIM.
REQ-019 LOAD (exactly 1 cycle): ld=1, gnt[sel]=1, -> CONTA.
REQ-020 CONTA: gnt[sel]=1; dec = ~zero; zero=1 -> FIM, else stay.
REQ-021 FIM (exactly 1 cycle): done[sel]=1, gnt[sel]=1, njobs <= njobs+1, -> IDLE.
REQ-022 Latency: value N loaded in LOAD cycle t -> dec high cycles t+1..t+N, done high cycle t+N+2.
REQ-023 N=0: no dec pulse, done at t+2.
REQ-024 req sampled only in IDLE; req drop during LOAD/CONTA ignored, job completes; req still high in IDLE after FIM is a new request.
REQ-025 sel, val stable from LOAD through FIM; at most one gnt and one done high at any time; ld and dec never simultaneously high.
REQ-026 req of non-granted requester during a job: held pending, serviced next IDLE per REQ-018.

Reset
REQ-027 rst=1 at any time, including mid-job: state=IDLE, prio=0, sel=0, njobs=0, ld=dec=gnt0=gnt1=done0=done1=0, pronto=1, immediately, no done for aborted job.
REQ-028 First rising edge after rst deasserts evaluates IDLE normally.

Verification
REQ-029 Single job: req0=1, val0=3 -> ld 1 cycle, dec exactly 3 cycles, done0 at t+5, njobs=1, pronto=1 after.
REQ-030 Zero value: req1=1, val1=0 -> ld, no dec, done1 at t+2, gnt1 high 3 cycles.
REQ-031 Contention: req0=req1=1 from reset, val0=2, val1=1 -> req0 served first, then req1; both held high -> grants alternate 0,1,0,1 over 4 jobs.
REQ-032 Reset mid-job: rst pulse during CONTA with val0=10 -> all outputs to reset values same cycle, no done0, njobs=0, prio=0.
REQ-033 Wrap: 256 back-to-back jobs val=0 -> njobs returns to 0.
REQ-034 Datapath model: bench models W-bit count register (ld loads val, dec decrements) and checks it never underflows and equals 0 at every done.

Source files
------------

// File: rtl/arb_contador.sv
// arb_contador: round-robin arbiter and sequencer that lends one
// countdown datapath to two requesters, one job at a time.
//
// Ports:
//   clk            system clock, all state on the rising edge
//   rst            asynchronous active-high reset
//   req0, req1     job requests, held with a stable value until done
//   val0, val1     countdown values of requester 0 / 1
//   zero           datapath flag, count register == 0
//   ld             datapath load strobe (count <= val)
//   val            value muxed to the datapath by sel
//   sel            index of the granted requester
//   dec            datapath decrement strobe
//   gnt0, gnt1     grant levels, requester owns the datapath
//   done0, done1   one-cycle job-complete pulses
//   pronto         idle, no job in progress
//   njobs          completed job count, wraps 255 -> 0
module arb_contador #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         req0,
   input  logic         req1,
   input  logic [W-1:0] val0,
   input  logic [W-1:0] val1,
   input  logic         zero,
   output logic         ld,
   output logic [W-1:0] val,
   output logic         sel,
   output logic         dec,
   output logic         gnt0,
   output logic         gnt1,
   output logic         done0,
   output logic         done1,
   output logic         pronto,
   output logic [7:0]   njobs
);

   typedef enum logic [1:0] {
      IDLE,
      LOAD,
      CONTA,
      FIM
   } state_t;

   state_t     state_q;
   state_t     state_d;
   logic       sel_q;
   logic       sel_d;
   logic       prio_q;
   logic       prio_d;
   logic [7:0] njobs_q;
   logic [7:0] njobs_d;

   logic       busy;
   logic       both;

   // State register; reset also aborts any job in flight, so no
   // done pulse is ever produced for it.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         sel_q   <= 1'b0;
         prio_q  <= 1'b0;
         njobs_q <= 8'd0;
      end else begin
         state_q <= state_d;
         sel_q   <= sel_d;
         prio_q  <= prio_d;
         njobs_q <= njobs_d;
      end
   end

   assign both = req0 & req1;

   // Next-state logic.  Requests are only looked at in IDLE; with
   // both pending the pointer decides, otherwise the lone
   // requester wins.  The pointer moves away from the winner as
   // the job finishes, so held requests alternate.
   always_comb begin
      state_d = state_q;
      sel_d   = sel_q;
      prio_d  = prio_q;
      njobs_d = njobs_q;
      unique case (state_q)
         IDLE: begin
            if (req0 | req1) begin
               state_d = LOAD;
               sel_d   = both ? prio_q : req1;
            end
         end
         LOAD: begin
            state_d = CONTA;
         end
         CONTA: begin
            if (zero) begin
               state_d = FIM;
               prio_d  = ~sel_q;
            end
         end
         FIM: begin
            state_d = IDLE;
            njobs_d = njobs_q + 8'd1;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // Outputs decode from registered state only; the value mux and
   // the zero-gated decrement are the only combinational paths.
   assign busy   = (state_q != IDLE);
   assign pronto = (state_q == IDLE);
   assign ld     = (state_q == LOAD);
   assign dec    = (state_q == CONTA) & ~zero;
   assign gnt0   = busy & ~sel_q;
   assign gnt1   = busy & sel_q;
   assign done0  = (state_q == FIM) & ~sel_q;
   assign done1  = (state_q == FIM) & sel_q;
   assign sel    = sel_q;
   assign val    = sel_q ? val1 : val0;
   assign njobs  = njobs_q;

endmodule

// File: tb/tb_arb_contador.sv
// Testbench for arb_contador: directed jobs, a scoreboard of
// expected completions and a model of the countdown datapath.
module tb_arb_contador;

   logic       clk = 1'b0;
   logic       rst;
   logic       req0, req1;
   logic [7:0] val0, val1;
   logic       zero;
   logic       ld, sel, dec;
   logic [7:0] vmux;
   logic       gnt0, gnt1, done0, done1, pronto;
   logic [7:0] njobs;

   arb_contador #(.W(8)) dut (
      .clk(clk), .rst(rst),
      .req0(req0), .req1(req1),
      .val0(val0), .val1(val1),
      .zero(zero), .ld(ld), .val(vmux), .sel(sel), .dec(dec),
      .gnt0(gnt0), .gnt1(gnt1),
      .done0(done0), .done1(done1),
      .pronto(pronto), .njobs(njobs)
   );

   always #5 clk = ~clk;

   typedef struct {
      int id;
      int n;
   } exp_t;

   exp_t sbq[$];
   int   pass_cnt = 0;
   int   tot_cnt = 0;
   int   cyc = 0;
   int   uflow = 0;
   logic [7:0] cnt = 8'd0;

   task automatic chk(input string nm, input int act, input int exp);
      tot_cnt++;
      if (act == exp) pass_cnt++;
      else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
   endtask

   task automatic push(input int id, input int n);
      exp_t e;
      e.id = id;
      e.n  = n;
      sbq.push_back(e);
   endtask

   // Datapath count register model
   assign zero = (cnt == 8'd0);
   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (ld) cnt <= vmux;
      else if (dec) begin
         if (cnt == 8'd0) uflow <= uflow + 1;
         cnt <= cnt - 8'd1;
      end
   end

   // Monitor
   bit in_job = 0;
   bit cur_sel = 0;
   int start = 0;
   int dec_n = 0;
   int gnt_n = 0;
   int model_jobs = 0;

   always @(negedge clk) begin
      exp_t e;
      int   inv;
      if (rst) begin
         sbq.delete();
         in_job = 0;
         model_jobs = 0;
      end else begin
         inv = 0;
         if (gnt0 & gnt1) inv |= 1;
         if (done0 & done1) inv |= 2;
         if (ld & dec) inv |= 4;
         if (pronto == (gnt0 | gnt1)) inv |= 8;
         if (in_job && (sel != cur_sel)) inv |= 16;
         chk("invariants", inv, 0);
         if (ld) begin
            in_job = 1;
            cur_sel = sel;
            start = cyc;
            dec_n = 0;
            gnt_n = 0;
            if (sbq.size() > 0) chk("ld_sel", int'(sel), sbq[0].id);
            chk("ld_val", int'(vmux), int'(sel ? val1 : val0));
         end
         if (in_job) begin
            if (gnt0 | gnt1) gnt_n++;
            if (dec) dec_n++;
         end
         if (done0 | done1) begin
            if (sbq.size() == 0) begin
               chk("unexpected_done", 1, 0);
            end else begin
               e = sbq.pop_front();
               chk("done_id", done1 ? 1 : 0, e.id);
               chk("dec_cycles", dec_n, e.n);
               chk("done_latency", cyc - start, e.n + 2);
               chk("gnt_cycles", gnt_n, e.n + 3);
               chk("cnt_at_done", int'(cnt), 0);
               chk("njobs_at_done", int'(njobs), model_jobs);
               model_jobs = (model_jobs + 1) % 256;
            end
            in_job = 0;
         end
      end
   end

   task automatic wait_dones(input int k);
      int seen = 0;
      int lim = k * 40 + 40;
      while (seen < k && lim > 0) begin
         @(negedge clk);
         if (done0 | done1) seen++;
         lim--;
      end
      if (seen < k) chk("done_timeout", seen, k);
   endtask

   task automatic wait_ld();
      int lim = 40;
      do begin
         @(negedge clk);
         lim--;
      end while (!ld && lim > 0);
      chk("ld_seen", int'(ld), 1);
   endtask

   task automatic rst_on();
      @(negedge clk);
      #2 rst = 1'b1;
   endtask

   task automatic rst_off();
      @(negedge clk);
      @(negedge clk);
      #2 rst = 1'b0;
   endtask

   task automatic chk_reset_outs(input string tag);
      chk({tag, "_pronto"}, int'(pronto), 1);
      chk({tag, "_ld"}, int'(ld), 0);
      chk({tag, "_dec"}, int'(dec), 0);
      chk({tag, "_gnt"}, int'({gnt1, gnt0}), 0);
      chk({tag, "_done"}, int'({done1, done0}), 0);
      chk({tag, "_sel"}, int'(sel), 0);
      chk({tag, "_njobs"}, int'(njobs), 0);
   endtask

   initial begin
      int nd;
      rst = 1'b1;
      req0 = 1'b0;
      req1 = 1'b0;
      val0 = 8'd0;
      val1 = 8'd0;
      repeat (2) @(negedge clk);
      #1 chk_reset_outs("reset");
      #1 rst = 1'b0;

      // Single job, value 3
      push(0, 3);
      val0 = 8'd3;
      req0 = 1'b1;
      wait_dones(1);
      req0 = 1'b0;
      @(negedge clk);
      chk("single_pronto", int'(pronto), 1);
      chk("single_njobs", int'(njobs), 1);

      // Zero value on requester 1
      push(1, 0);
      val1 = 8'd0;
      req1 = 1'b1;
      wait_dones(1);
      req1 = 1'b0;
      @(negedge clk);
      chk("zero_njobs", int'(njobs), 2);

      // Contention from reset, both held for four jobs
      rst_on();
      val0 = 8'd2;
      val1 = 8'd1;
      req0 = 1'b1;
      req1 = 1'b1;
      rst_off();
      push(0, 2);
      push(1, 1);
      push(0, 2);
      push(1, 1);
      wait_dones(4);
      req0 = 1'b0;
      req1 = 1'b0;
      @(negedge clk);
      chk("contend_njobs", int'(njobs), 4);

      // Job on 0 moves the pointer to 1 before the abort
      push(0, 1);
      val0 = 8'd1;
      req0 = 1'b1;
      wait_dones(1);
      req0 = 1'b0;
      @(negedge clk);

      // Reset in the middle of a 10-cycle countdown
      push(0, 10);
      val0 = 8'd10;
      req0 = 1'b1;
      wait_ld();
      repeat (3) @(negedge clk);
      chk("abort_dec_before", int'(dec), 1);
      chk("abort_gnt0_before", int'(gnt0), 1);
      #2 rst = 1'b1;
      #1 chk_reset_outs("abort");
      req0 = 1'b0;
      rst_off();
      nd = 0;
      repeat (20) begin
         @(negedge clk);
         if (done0 | done1) nd++;
      end
      chk("abort_no_done", nd, 0);
      chk("abort_njobs", int'(njobs), 0);

      // Pointer back at 0: requester 0 wins first
      push(0, 0);
      push(1, 0);
      val0 = 8'd0;
      val1 = 8'd0;
      req0 = 1'b1;
      req1 = 1'b1;
      wait_dones(2);
      req0 = 1'b0;
      req1 = 1'b0;
      @(negedge clk);
      chk("prio_njobs", int'(njobs), 2);

      // 256 back-to-back jobs wrap the job counter
      rst_on();
      val0 = 8'd0;
      req0 = 1'b1;
      rst_off();
      for (int i = 0; i < 256; i++) push(0, 0);
      wait_dones(256);
      req0 = 1'b0;
      @(negedge clk);
      chk("wrap_njobs", int'(njobs), 0);
      chk("wrap_pronto", int'(pronto), 1);

      repeat (3) @(negedge clk);
      chk("queue_empty", sbq.size(), 0);
      chk("no_underflow", uflow, 0);
      $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
      $finish;
   end

endmodule
